// File: rtl/mux_arb_pkg.sv
// -----------------------------------------------------------------------------
// mux_arb_pkg
// Shared definitions for the round-robin arbitrated 4:1 mux.
//   NREQ        : number of requesters
//   SELW        : width of a requester index / mux select
//   arb_state_e : arbiter FSM states (IDLE arbitrates, GRANT transfers)
//   sel_decode  : index -> one-hot grant vector
// -----------------------------------------------------------------------------
package mux_arb_pkg;

    localparam int NREQ = 4;
    localparam int SELW = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // One-hot decode of a requester index.
    function automatic logic [NREQ-1:0] sel_decode(input logic [SELW-1:0] s);
        logic [NREQ-1:0] v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin picker. Searches req starting at index ptr
// and moving upward, wrapping from NREQ-1 back to 0; the first set bit wins.
// Ports:
//   req     [NREQ-1:0] in  : request vector
//   ptr     [SELW-1:0] in  : index with highest priority this round
//   idx     [SELW-1:0] out : winning index (equals ptr when nothing requests)
//   any_req            out : at least one request bit is set
// -----------------------------------------------------------------------------
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] idx,
    output logic            any_req
);

    // cand[k] is the index visited at search position k; hit[k] says whether
    // that index is requesting. Index arithmetic wraps naturally at SELW bits.
    logic [SELW-1:0] cand [NREQ];
    logic [NREQ-1:0] hit;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
        assign cand[gi] = ptr + SELW'(gi);
        assign hit[gi]  = req[cand[gi]];
    end

    // Walk from the farthest search position towards the nearest so the
    // nearest hit is the one that sticks.
    always_comb begin
        idx = ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                idx = cand[k];
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux_rr_arbiter
// Round-robin arbiter steering a registered 4:1 mux. In IDLE the next
// requester (searched from ptr upward) is granted; in GRANT one bit is moved
// from a[sel] to y on every cycle the granted requester keeps req high. The
// grant ends on last, on a dropped request, or after HOLD_MAX transfers, and
// is always followed by exactly one IDLE cycle.
// Parameters:
//   HOLD_MAX : maximum transfers per grant, 1..15 (clamped into that range)
// Ports:
//   clk              in  : clock, rising edge
//   rst_n            in  : asynchronous active-low reset
//   req   [NREQ-1:0] in  : per-requester request
//   last  [NREQ-1:0] in  : per-requester final-transfer flag (qualified by req)
//   a     [NREQ-1:0] in  : per-requester 1-bit data
//   sel   [SELW-1:0] out : registered mux select / granted index
//   gnt   [NREQ-1:0] out : registered one-hot grant, zero when idle
//   busy             out : high while in GRANT
//   y                out : registered mux output
//   y_vld            out : one-cycle pulse per accepted transfer
// -----------------------------------------------------------------------------
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int HOLD_MAX = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] last,
    input  logic [NREQ-1:0] a,
    output logic [SELW-1:0] sel,
    output logic [NREQ-1:0] gnt,
    output logic            busy,
    output logic            y,
    output logic            y_vld
);

    // Hold counter is 4 bits, so keep the limit inside 1..15.
    localparam logic [3:0] HOLD_LIM =
        (HOLD_MAX < 1)  ? 4'd1  :
        (HOLD_MAX > 15) ? 4'd15 : 4'(HOLD_MAX);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    arb_state_e      state_q, state_d;
    logic [SELW-1:0] ptr_q,   ptr_d;
    logic [SELW-1:0] sel_q,   sel_d;
    logic [NREQ-1:0] gnt_q,   gnt_d;
    logic            y_q,     y_d;
    logic            y_vld_q, y_vld_d;
    logic [3:0]      hold_q,  hold_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [SELW-1:0] pick_idx;
    logic            pick_any;

    rr_pick u_rr_pick (
        .req     (req),
        .ptr     (ptr_q),
        .idx     (pick_idx),
        .any_req (pick_any)
    );

    // ------------------------------------------------------------------
    // Granted-requester view. Only the requester at sel_q is looked at, so
    // everybody else's req/last/a is ignored during GRANT.
    // ------------------------------------------------------------------
    logic       req_sel;
    logic       last_sel;
    logic [3:0] hold_inc;
    logic       hit_max;
    logic       rel;

    assign req_sel  = req[sel_q];
    assign last_sel = last[sel_q] & req_sel;   // last only counts with req
    assign hold_inc = hold_q + 4'd1;
    assign hit_max  = req_sel && (hold_inc == HOLD_LIM);

    // Any release cause collapses into one release; the transfer that
    // triggers last/limit is still performed and counted once.
    assign rel = (state_q == GRANT) && (!req_sel || last_sel || hit_max);

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        y_d     = y_q;
        y_vld_d = 1'b0;
        hold_d  = hold_q;

        case (state_q)
            IDLE: begin
                gnt_d  = '0;
                hold_d = '0;
                if (pick_any) begin
                    state_d = GRANT;
                    sel_d   = pick_idx;
                    gnt_d   = sel_decode(pick_idx);
                end
            end

            GRANT: begin
                if (req_sel) begin
                    y_d     = a[sel_q];
                    y_vld_d = 1'b1;
                    hold_d  = hold_inc;
                end
                if (rel) begin
                    // sel keeps its value through the idle cycle; only the
                    // priority pointer moves past the requester just served.
                    state_d = IDLE;
                    gnt_d   = '0;
                    hold_d  = '0;
                    ptr_d   = sel_q + 2'd1;
                end
            end

            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                hold_d  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            gnt_q   <= '0;
            y_q     <= 1'b0;
            y_vld_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            y_q     <= y_d;
            y_vld_q <= y_vld_d;
            hold_q  <= hold_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign sel   = sel_q;
    assign gnt   = gnt_q;
    assign busy  = (state_q == GRANT);
    assign y     = y_q;
    assign y_vld = y_vld_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] last;
    logic [3:0] a;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       busy;
    logic       y;
    logic       y_vld;

    int checks = 0;
    int errors = 0;

    // Expected transfers: {granted index, data bit}
    logic [2:0] sb [$];

    mux_rr_arbiter #(.HOLD_MAX(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .last  (last),
        .a     (a),
        .sel   (sel),
        .gnt   (gnt),
        .busy  (busy),
        .y     (y),
        .y_vld (y_vld)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int oh_idx(input logic [3:0] v);
        int r = 0;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Monitor: every y_vld pulse must match the oldest expected transfer.
    always @(negedge clk) begin
        if (y_vld) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_y_vld: got pulse sel=%0d y=%0d expected none at %0t",
                         sel, y, $time);
            end else begin
                logic [2:0] e;
                e = sb.pop_front();
                check("xfer_sel", sel, e[2:1]);
                check("xfer_y", y, e[0]);
                $display("xfer sel=%0d y=%0d (exp sel=%0d y=%0d)", sel, y, e[2:1], e[0]);
            end
        end
    end

    // One cycle: drive inputs (called at posedge+1), optionally log an expected
    // transfer, check grant state mid-cycle, return at next posedge+1.
    task automatic cyc(input logic [3:0] r, input logic [3:0] l, input logic [3:0] av,
                       input logic [3:0] exp_gnt, input bit push, input logic [1:0] pidx);
        req  = r;
        last = l;
        a    = av;
        if (push) sb.push_back({pidx, av[pidx]});
        @(negedge clk);
        check("gnt", gnt, exp_gnt);
        check("busy", busy, exp_gnt != 4'b0);
        if (exp_gnt != 4'b0) check("sel", sel, oh_idx(exp_gnt));
        $display("cycle req=%b last=%b a=%b gnt=%b sel=%0d busy=%0d", r, l, av, gnt, sel, busy);
        @(posedge clk);
        #1;
    endtask

    task automatic sb_drained(input string name);
        check(name, sb.size(), 0);
    endtask

    initial begin
        logic [3:0] av;
        logic [3:0] eg;
        logic [3:0] l;
        int         g;

        rst_n = 1'b0;
        req   = '0;
        last  = '0;
        a     = '0;

        // ---- reset state, then idle with req = 0 ----
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_sel", sel, 0);
        check("rst_busy", busy, 0);
        check("rst_y", y, 0);
        check("rst_y_vld", y_vld, 0);
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            cyc(4'b0000, 4'b0000, 4'($urandom), 4'b0000, 1'b0, 2'd0);
            check("idle_sel", sel, 0);
            check("idle_y_vld", y_vld, 0);
        end

        // ---- req = 1111, last on 3rd transfer: grants 0,1,2,3,0 ----
        for (int n = 0; n < 20; n++) begin
            g  = (n / 4) % 4;
            eg = (n % 4 == 0) ? 4'b0000 : 4'(1 << g);
            l  = (n % 4 == 3) ? 4'b1111 : 4'b0000;
            av = 4'($urandom);
            cyc(4'b1111, l, av, eg, n % 4 != 0, 2'(g));
        end
        cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
        cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
        sb_drained("rr_order_drained");

        // ---- HOLD_MAX limit on requester 2, then re-grant ----
        cyc(4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
        for (int n = 1; n <= 8; n++) begin
            av    = 4'($urandom);
            av[2] = (n % 2) == 1;
            cyc(4'b0100, 4'b0000, av, 4'b0100, 1'b1, 2'd2);
        end
        cyc(4'b0100, 4'b0000, 4'($urandom), 4'b0000, 1'b0, 2'd0);
        cyc(4'b0000, 4'b0000, 4'($urandom), 4'b0100, 1'b0, 2'd0);
        cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
        sb_drained("hold_max_drained");

        // ---- requester 1 drops req while 3 waits ----
        cyc(4'b0010, 4'b0000, 4'($urandom), 4'b0000, 1'b0, 2'd0);
        cyc(4'b1010, 4'b1000, 4'($urandom), 4'b0010, 1'b1, 2'd1);
        cyc(4'b1010, 4'b1000, 4'($urandom), 4'b0010, 1'b1, 2'd1);
        cyc(4'b1000, 4'b0010, 4'($urandom), 4'b0010, 1'b0, 2'd0);
        cyc(4'b1000, 4'b0000, 4'($urandom), 4'b0000, 1'b0, 2'd0);
        cyc(4'b1000, 4'b1000, 4'($urandom), 4'b1000, 1'b1, 2'd3);
        cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
        sb_drained("drop_req_drained");

        // ---- last coincides with the HOLD_MAX-th transfer ----
        cyc(4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
        for (int n = 1; n <= 8; n++) begin
            av = 4'($urandom);
            if (n == 8) av[0] = 1'b1;
            cyc(4'b0001, (n == 8) ? 4'b0001 : 4'b0000, av, 4'b0001, 1'b1, 2'd0);
        end
        cyc(4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
        cyc(4'b0000, 4'b0000, 4'b0000, 4'b0010, 1'b0, 2'd0);
        cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
        sb_drained("coincide_drained");

        // ---- reset pulse during the grant of requester 3 ----
        cyc(4'b1000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
        req = 4'b1000;
        #1;
        check("pre_rst_gnt", gnt, 4'b1000);
        check("pre_rst_sel", sel, 3);
        check("pre_rst_y", y, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_gnt", gnt, 0);
        check("async_rst_sel", sel, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_y", y, 0);
        check("async_rst_y_vld", y_vld, 0);
        $display("reset pulse gnt=%b sel=%0d busy=%0d y=%0d y_vld=%0d", gnt, sel, busy, y, y_vld);
        @(posedge clk);
        #1;
        req = 4'b1010;
        #1;
        rst_n = 1'b1;
        cyc(4'b1010, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
        cyc(4'b0000, 4'b0000, 4'b0000, 4'b0010, 1'b0, 2'd0);
        cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
        sb_drained("post_rst_drained");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
